datapath_seq_ctrl: RTL and testbench

//   Sequencer for the 4-bit accumulate datapath (register + 2:1 input mux + ALU with carry).

---
 rtl/datapath_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_datapath_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_seq_ctrl.sv
// rtl/datapath_seq_ctrl.sv - command sequencer for the 4-bit accumulate datapath
//
// Takes one command (init, operand, op, count) per cmd handshake. It loads init
// into the datapath register and then runs reg <= reg OP operand count times.
// The final register value and the OR of all iteration carries are returned on
// the res handshake. All outputs are Moore-decoded from state and captured
// registers.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_valid / cmd_ready     command handshake
//   cmd_init, cmd_operand     initial register value, per-iteration ALU operand
//   cmd_op, cmd_count         ALU select, iteration count (0 allowed)
//   dp_load, dp_mux_sel       datapath register enable, 0=external load 1=feedback
//   dp_mux_in, dp_alu_in      datapath load value, ALU operand
//   dp_alu_sel                datapath ALU select
//   dp_carry_out, dp_reg_out  datapath ALU carry, datapath register value
//   res_valid / res_ready     result handshake
//   res_data, res_carry       final register value, sticky carry
module datapath_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_init,
    input  logic [WIDTH-1:0] cmd_operand,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             dp_load,
    output logic             dp_mux_sel,
    output logic [WIDTH-1:0] dp_mux_in,
    output logic [WIDTH-1:0] dp_alu_in,
    output logic [1:0]       dp_alu_sel,
    input  logic             dp_carry_out,
    input  logic [WIDTH-1:0] dp_reg_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  init_q;
    logic [WIDTH-1:0]  operand_q;
    logic [1:0]        op_q;
    logic [CNT_W-1:0]  iter_q;
    logic              sticky_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // iter_q is loaded with the command count at capture and serves directly
    // as the remaining-iterations counter during RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_q    <= '0;
            operand_q <= '0;
            op_q      <= '0;
            iter_q    <= '0;
            sticky_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        init_q    <= cmd_init;
                        operand_q <= cmd_operand;
                        op_q      <= cmd_op;
                        iter_q    <= cmd_count;
                        sticky_q  <= 1'b0;
                    end
                end
                RUN: begin
                    sticky_q <= sticky_q | dp_carry_out;
                    iter_q   <= iter_q - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt = INIT;
                end
            end
            INIT: begin
                if (iter_q == '0) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // The last iteration is the one that starts with one remaining.
                if (iter_q <= CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_ready  = (state == IDLE);
    assign dp_load    = (state == INIT) || (state == RUN);
    assign dp_mux_sel = (state == RUN);
    assign dp_mux_in  = init_q;
    assign dp_alu_in  = operand_q;
    assign dp_alu_sel = op_q;
    assign res_valid  = (state == DONE);
    assign res_data   = (state == DONE) ? dp_reg_out : '0;
    assign res_carry  = (state == DONE) ? sticky_q : 1'b0;

endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// tb/tb_datapath_seq_ctrl.sv - self-checking bench for datapath_seq_ctrl
module tb_datapath_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_init;
    logic [3:0] cmd_operand;
    logic [1:0] cmd_op;
    logic [3:0] cmd_count;
    logic       dp_load;
    logic       dp_mux_sel;
    logic [3:0] dp_mux_in;
    logic [3:0] dp_alu_in;
    logic [1:0] dp_alu_sel;
    logic       dp_carry_out;
    logic [3:0] dp_reg_out;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_carry;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    datapath_seq_ctrl #(.WIDTH(4), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_init     (cmd_init),
        .cmd_operand  (cmd_operand),
        .cmd_op       (cmd_op),
        .cmd_count    (cmd_count),
        .dp_load      (dp_load),
        .dp_mux_sel   (dp_mux_sel),
        .dp_mux_in    (dp_mux_in),
        .dp_alu_in    (dp_alu_in),
        .dp_alu_sel   (dp_alu_sel),
        .dp_carry_out (dp_carry_out),
        .dp_reg_out   (dp_reg_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_carry    (res_carry)
    );

    // Datapath: register with no reset, 2:1 input mux, ALU with carry.
    // ALU ops: 11 ADD (carry out), 01 SUB (borrow as carry), 00 AND, 10 XOR.
    logic [4:0] alu_full;
    logic [3:0] dp_reg;

    always_comb begin
        alu_full = '0;
        case (dp_alu_sel)
            2'b11:   alu_full = {1'b0, dp_reg} + {1'b0, dp_alu_in};
            2'b01:   alu_full = {1'b0, dp_reg} - {1'b0, dp_alu_in};
            2'b00:   alu_full = {1'b0, dp_reg & dp_alu_in};
            default: alu_full = {1'b0, dp_reg ^ dp_alu_in};
        endcase
    end

    always @(posedge clk) begin
        if (dp_load) begin
            dp_reg <= dp_mux_sel ? alu_full[3:0] : dp_mux_in;
        end
    end

    assign dp_carry_out = alu_full[4];
    assign dp_reg_out   = dp_reg;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: apply the op n times with integer arithmetic, OR the carries.
    function automatic logic [4:0] ref_result(input logic [3:0] init, input logic [3:0] operand,
                                              input logic [1:0] op, input int n);
        int acc;
        bit cy;
        acc = int'(init);
        cy  = 1'b0;
        for (int i = 0; i < n; i++) begin
            case (op)
                2'b11: begin
                    acc = acc + int'(operand);
                    if (acc > 15) begin
                        cy  = 1'b1;
                        acc = acc - 16;
                    end
                end
                2'b01: begin
                    if (acc < int'(operand)) begin
                        cy  = 1'b1;
                        acc = acc + 16;
                    end
                    acc = acc - int'(operand);
                end
                2'b00:   acc = acc & int'(operand);
                default: acc = acc ^ int'(operand);
            endcase
        end
        return {cy, 4'(acc)};
    endfunction

    task automatic run_cmd(input logic [3:0] init, input logic [3:0] operand, input logic [1:0] op,
                           input logic [3:0] n, input int hold, input bit junk);
        logic [4:0] exp;
        logic [3:0] d0;
        logic       c0;
        int         lat;
        int         runs;
        exp = ref_result(init, operand, op, int'(n));
        @(negedge clk);
        lat = 0;
        while (!cmd_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check_eq("cmd_ready_wait", cmd_ready, 1);
        cmd_valid   = 1'b1;
        cmd_init    = init;
        cmd_operand = operand;
        cmd_op      = op;
        cmd_count   = n;
        @(posedge clk);
        #1;
        cmd_valid   = 1'b0;
        cmd_init    = 4'($urandom);
        cmd_operand = 4'($urandom);
        cmd_op      = 2'($urandom);
        cmd_count   = 4'($urandom);
        lat  = 0;
        runs = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (dp_mux_sel) runs++;
            if (res_valid) break;
        end
        check_eq("latency", lat, int'(n) + 2);
        check_eq("run_cycles", runs, int'(n));
        check_eq("res_data", res_data, exp[3:0]);
        check_eq("res_carry", res_carry, exp[4]);
        check_eq("done_load", dp_load, 0);
        d0 = res_data;
        c0 = res_carry;
        for (int h = 0; h < hold; h++) begin
            if (junk) begin
                cmd_valid   = 1'b1;
                cmd_init    = ~init;
                cmd_operand = ~operand;
                cmd_op      = ~op;
                cmd_count   = 4'($urandom);
            end
            @(negedge clk);
            check_eq("hold_valid", res_valid, 1);
            check_eq("hold_data", res_data, d0);
            check_eq("hold_carry", res_carry, c0);
            check_eq("hold_ready", cmd_ready, 0);
            check_eq("hold_mux_in", dp_mux_in, init);
            check_eq("hold_alu_in", dp_alu_in, operand);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check_eq("post_valid", res_valid, 0);
        check_eq("post_ready", cmd_ready, 1);
    endtask

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_init    = '0;
        cmd_operand = '0;
        cmd_op      = '0;
        cmd_count   = '0;
        res_ready   = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_dp_load", dp_load, 0);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_mux_in", dp_mux_in, 0);
        rst = 1'b0;

        run_cmd(4'b0101, 4'b0001, 2'b11, 4'd3, 1, 1'b0);
        run_cmd(4'b1110, 4'b0011, 2'b11, 4'd1, 0, 1'b0);
        run_cmd(4'b1010, 4'b0110, 2'b11, 4'd0, 0, 1'b0);
        run_cmd(4'b0111, 4'b1000, 2'b00, 4'd2, 0, 1'b0);
        run_cmd(4'b0011, 4'b0101, 2'b01, 4'd2, 4, 1'b1);
        run_cmd(4'b1001, 4'b0010, 2'b10, 4'd15, 0, 1'b0);

        // Reset in the middle of a long RUN.
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_init    = 4'd5;
        cmd_operand = 4'd1;
        cmd_op      = 2'b11;
        cmd_count   = 4'd15;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("mid_run_sel", dp_mux_sel, 1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("arst_cmd_ready", cmd_ready, 1);
        check_eq("arst_dp_load", dp_load, 0);
        check_eq("arst_mux_sel", dp_mux_sel, 0);
        check_eq("arst_mux_in", dp_mux_in, 0);
        check_eq("arst_alu_in", dp_alu_in, 0);
        check_eq("arst_alu_sel", dp_alu_sel, 0);
        check_eq("arst_res_valid", res_valid, 0);
        check_eq("arst_res_carry", res_carry, 0);
        cmd_valid   = 1'b1;
        cmd_init    = 4'd9;
        cmd_count   = 4'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        check_eq("rel_cmd_ready", cmd_ready, 1);
        check_eq("rel_dp_load", dp_load, 0);
        run_cmd(4'b0101, 4'b0001, 2'b11, 4'd3, 0, 1'b0);

        for (int k = 0; k < 30; k++) begin
            run_cmd(4'($urandom), 4'($urandom), 2'($urandom), 4'($urandom),
                    int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
